// File: rtl/pmem_pkg.sv
// Shared types and helpers for the banked program/data memory.
// Optional per-byte parity is enabled by defining PMEM_PARITY_EN.
package pmem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pmem_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic parity8(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/pmem_bank.sv
// One interleaved bank: BDEPTH rows of NB byte lanes (LW bits each, parity included
// when PMEM_PARITY_EN is defined), per-lane write enables and a registered read port.
module pmem_bank
    import pmem_pkg::*;
#(
    parameter int NB     = 2,
    parameter int LW     = 8,
    parameter int BDEPTH = 16,
    parameter int RW     = 4
) (
    input  logic                   clk,
    input  logic                   rd_en,
    input  logic [NB-1:0]          we,
    input  logic [RW-1:0]          row,
    input  logic [NB-1:0][LW-1:0]  wdata,
    output logic [NB-1:0][LW-1:0]  rdata
);

    logic [NB-1:0][LW-1:0] mem [BDEPTH];

    // Non-blocking update gives read-before-write on a shared row.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we[i]) mem[row][i] <= wdata[i];
        end
        if (rd_en) rdata <= mem[row];
    end

endmodule

// File: rtl/pmem_banked.sv
// Banked program/data memory with self-clearing init sequencer and range check.
// Define PMEM_PARITY_EN to store and check one even-parity bit per byte lane.
module pmem_banked
    import pmem_pkg::*;
#(
    parameter int ADDR_MSB   = 11,
    parameter int MEM_SIZE   = 8192,
    parameter int DATA_WIDTH = 16,
    parameter int BANKS      = 2
) (
    input  logic                    ram_clk,
    input  logic                    ram_rst,
    input  logic [ADDR_MSB:0]       ram_addr,
    input  logic                    ram_cen,
    input  logic [DATA_WIDTH/8-1:0] ram_wen,
    input  logic [DATA_WIDTH-1:0]   ram_din,
    output logic [DATA_WIDTH-1:0]   ram_dout,
    input  logic                    init_req,
    output logic                    init_busy,
    output logic                    oor_err,
    output logic                    parity_err
);

    localparam int NB     = DATA_WIDTH / 8;
    localparam int DEPTH  = MEM_SIZE / NB;
    localparam int BDEPTH = DEPTH / BANKS;
    localparam int SELB   = clog2(BANKS);
    localparam int SW     = (SELB > 0) ? SELB : 1;
    localparam int RW     = (clog2(BDEPTH) > 0) ? clog2(BDEPTH) : 1;
`ifdef PMEM_PARITY_EN
    localparam int PB     = 1;
`else
    localparam int PB     = 0;
`endif
    localparam int LW     = 8 + PB;

    pmem_state_t state, state_nxt;
    logic [RW-1:0] init_cnt, init_cnt_nxt;
    logic [31:0]   addr32;
    logic [SW-1:0] sel, sel_q;
    logic [RW-1:0] cpu_row, row;
    logic          oor, access, hit, last_row, init_wr;
    logic          zero_q, oor_q;
    logic [NB-1:0][LW-1:0]            wdata;
    logic [BANKS-1:0][NB-1:0][LW-1:0] rdata;

    assign addr32   = 32'(ram_addr);
    assign sel      = SW'(addr32 & 32'(BANKS - 1));
    assign cpu_row  = RW'(addr32 >> SELB);
    assign oor      = addr32 >= 32'(DEPTH);
    assign last_row = init_cnt == RW'(BDEPTH - 1);
    assign init_wr  = (state == ST_INIT) && !ram_rst;
    assign access   = (state == ST_RUN) && !ram_cen && !ram_rst;
    assign hit      = access && !oor;
    assign row      = (state == ST_INIT) ? init_cnt : cpu_row;
    assign init_busy = (state == ST_INIT);

    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // init_req only matters in ST_RUN; a running clear is never restarted by it.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = '0;
        case (state)
            ST_INIT: begin
                if (last_row) state_nxt = ST_RUN;
                else          init_cnt_nxt = init_cnt + RW'(1);
            end
            ST_RUN: begin
                if (init_req) state_nxt = ST_INIT;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        logic [7:0] b;
        b     = '0;
        wdata = '0;
        for (int i = 0; i < NB; i++) begin
            b = (state == ST_INIT) ? 8'h00 : ram_din[8*i +: 8];
`ifdef PMEM_PARITY_EN
            wdata[i] = {parity8(b), b};
`else
            wdata[i] = b;
`endif
        end
    end

    // Init writes all banks in parallel; CPU accesses touch only the selected bank.
    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        logic          bank_hit;
        logic [NB-1:0] we;

        assign bank_hit = hit && (sel == SW'(g));
        assign we       = init_wr ? '1 : (bank_hit ? ~ram_wen : '0);

        pmem_bank #(
            .NB     (NB),
            .LW     (LW),
            .BDEPTH (BDEPTH),
            .RW     (RW)
        ) u_bank (
            .clk   (ram_clk),
            .rd_en (bank_hit),
            .we    (we),
            .row   (row),
            .wdata (wdata),
            .rdata (rdata[g])
        );
    end

    // zero_q forces the output to 0 after reset, out-of-range accesses and
    // init cycles; otherwise the last serviced bank word is held.
    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            zero_q <= 1'b1;
            oor_q  <= 1'b0;
            sel_q  <= '0;
        end else begin
            oor_q <= access && oor;
            if (access) begin
                zero_q <= oor;
                if (!oor) sel_q <= sel;
            end else if (state == ST_INIT) begin
                zero_q <= 1'b1;
            end
        end
    end

    assign oor_err = oor_q;

    always_comb begin
        ram_dout = '0;
        if (!zero_q) begin
            for (int i = 0; i < NB; i++) ram_dout[8*i +: 8] = rdata[sel_q][i][7:0];
        end
    end

`ifdef PMEM_PARITY_EN
    logic rd_q, perr;

    always_ff @(posedge ram_clk) begin
        if (ram_rst) rd_q <= 1'b0;
        else         rd_q <= hit;
    end

    always_comb begin
        perr = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (parity8(rdata[sel_q][i][7:0]) != rdata[sel_q][i][8]) perr = 1'b1;
        end
    end

    assign parity_err = rd_q && perr;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_banked.sv
// Scoreboard bench for pmem_banked: a word-array reference model queues expected
// outputs at issue time; a negedge monitor pops and compares them.
module tb_pmem_banked;

    localparam int AW     = 6;
    localparam int DW     = 16;
    localparam int NBL    = 2;
    localparam int DEPTH  = 32;
    localparam int BDEPTH = 16;

    logic           ram_clk = 1'b0;
    logic           ram_rst = 1'b1;
    logic [AW-1:0]  ram_addr = '0;
    logic           ram_cen = 1'b1;
    logic [NBL-1:0] ram_wen = '1;
    logic [DW-1:0]  ram_din = '0;
    logic [DW-1:0]  ram_dout;
    logic           init_req = 1'b0;
    logic           init_busy, oor_err, parity_err;

    pmem_banked #(
        .ADDR_MSB   (AW - 1),
        .MEM_SIZE   (64),
        .DATA_WIDTH (DW),
        .BANKS      (2)
    ) dut (
        .ram_clk    (ram_clk),
        .ram_rst    (ram_rst),
        .ram_addr   (ram_addr),
        .ram_cen    (ram_cen),
        .ram_wen    (ram_wen),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .init_req   (init_req),
        .init_busy  (init_busy),
        .oor_err    (oor_err),
        .parity_err (parity_err)
    );

    always #5 ram_clk = ~ram_clk;

    typedef struct {
        int          due;
        logic [15:0] dout;
        bit          oor;
        bit          perr;
    } exp_t;

    exp_t        q[$];
    logic [15:0] model [DEPTH];
    logic [15:0] last = '0;
    bit          inj_perr = 0;
    bit          req_next = 0;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    always @(posedge ram_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge ram_clk) begin : mon
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("dout", ram_dout, e.dout);
            chk("oor_err", oor_err, e.oor);
            chk("parity_err", parity_err, e.perr);
        end else if (!ram_rst) begin
            chk("oor_idle", oor_err, 0);
        end
    end

    // One cycle of CPU stimulus; the model answers from word-level rules.
    task automatic acc(input bit c, input int a, input logic [1:0] w, input logic [15:0] d);
        exp_t e;
        @(negedge ram_clk);
        ram_cen  = c;
        ram_addr = AW'(a);
        ram_wen  = w;
        ram_din  = d;
        init_req = req_next;
        req_next = 0;
        e.due  = cyc + 1;
        e.oor  = 0;
        e.perr = inj_perr;
        inj_perr = 0;
        if (!c && a >= DEPTH) begin
            e.dout = '0;
            e.oor  = 1;
        end else if (!c) begin
            e.dout = model[a];
            for (int i = 0; i < NBL; i++) if (!w[i]) model[a][8*i +: 8] = d[8*i +: 8];
        end else begin
            e.dout = last;
        end
        last = e.dout;
        q.push_back(e);
    endtask

    task automatic drive_junk();
        ram_cen  = 1'($urandom);
        ram_addr = AW'($urandom);
        ram_wen  = NBL'($urandom);
        ram_din  = DW'($urandom);
    endtask

    // Counts cycles until init_busy drops, optionally pulsing init_req or
    // asserting reset at given counts; a reset restarts the count.
    task automatic wait_init(input int req_at, input int rst_at);
        int n;
        bit fired;
        n = 0;
        fired = 0;
        while (1) begin
            @(negedge ram_clk);
            init_req = 0;
            if (ram_rst) begin
                ram_rst = 0;
                n = 0;
                drive_junk();
                continue;
            end
            n++;
            if (!init_busy || n > 64) break;
            drive_junk();
            if (n == req_at) init_req = 1;
            if (n == rst_at && !fired) begin
                fired = 1;
                ram_rst = 1;
            end
        end
        ram_cen = 1;
        chk("init_cycles", n, BDEPTH);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        last = '0;
    endtask

    task automatic readback();
        for (int a = 0; a < DEPTH; a++) acc(0, a, 2'b11, 16'($urandom));
    endtask

    initial begin
        repeat (3) @(negedge ram_clk);
        chk("rst_busy", init_busy, 1);
        chk("rst_dout", ram_dout, 0);
        chk("rst_oor", oor_err, 0);
        chk("rst_perr", parity_err, 0);

        wait_init(0, 0);
        readback();

        acc(0, 5, 2'b00, 16'hA5C3);
        acc(0, 5, 2'b01, 16'h11EE);
        acc(0, 5, 2'b11, 16'h0000);
        acc(0, 2, 2'b00, 16'h1234);
        acc(0, 3, 2'b00, 16'h5678);
        acc(0, 2, 2'b11, 16'h0);
        acc(0, 3, 2'b11, 16'h0);
        acc(0, 2, 2'b11, 16'h0);
        acc(1, 0, 2'b11, 16'h0);

        acc(0, 40, 2'b00, 16'hBEEF);
        acc(1, 0, 2'b11, 16'h0);
        acc(1, 0, 2'b11, 16'h0);
        readback();

        for (int i = 0; i < 400; i++)
            acc($urandom_range(0, 4) == 0, $urandom_range(0, 47), 2'($urandom), 16'($urandom));
        readback();

`ifdef PMEM_PARITY_EN
        acc(0, 7, 2'b00, 16'h00FF);
        acc(1, 0, 2'b11, 16'h0);
        dut.g_bank[1].u_bank.mem[3][0][0] = ~dut.g_bank[1].u_bank.mem[3][0][0];
        model[7] = 16'h00FE;
        inj_perr = 1;
        acc(0, 7, 2'b11, 16'h0);
        acc(1, 0, 2'b11, 16'h0);
        inj_perr = 1;
        acc(0, 7, 2'b00, 16'h3C3C);
        acc(0, 7, 2'b11, 16'h0);
        acc(0, 6, 2'b11, 16'h0);
`endif

        // Request with a concurrent read; second pulse mid-sequence is ignored.
        req_next = 1;
        acc(0, 5, 2'b11, 16'h0);
        @(negedge ram_clk);
        init_req = 0;
        ram_cen  = 1;
        chk("busy_after_req", init_busy, 1);
        wait_init(5, 0);
        readback();

        // Reset in the middle of a later sequence restarts it.
        for (int i = 0; i < 40; i++)
            acc(0, $urandom_range(0, 31), 2'($urandom), 16'($urandom));
        req_next = 1;
        acc(1, 0, 2'b11, 16'h0);
        @(negedge ram_clk);
        init_req = 0;
        chk("busy_after_req2", init_busy, 1);
        wait_init(0, 8);
        readback();

        for (int i = 0; i < 3; i++) acc(1, 0, 2'b11, 16'h0);
        repeat (2) @(negedge ram_clk);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/pmem_banked.md
# pmem_banked

Parametrised, banked program/data memory for the openMSP430-based core, successor to the fixed single-array program-memory wrapper. It serves the CPU's `ram_*` memory port with configurable word width, byte size, and low-order address interleaving across banks. It adds a self-clearing init sequencer that runs after reset or on request, out-of-range detection, and optional per-byte parity.

## Interface
Parameters:
- `ADDR_MSB`, 11: MSB of the word address; the address space is 2^(`ADDR_MSB`+1) words.
- `MEM_SIZE`, 8192: implemented size in bytes. Must be a multiple of `BANKS`×`DATA_WIDTH`/8.
- `DATA_WIDTH`, 16: word width in bits. Must be a multiple of 8. `NB` = `DATA_WIDTH`/8 byte lanes.
- `BANKS`, 2: number of interleaved banks. Must be a power of 2, ≥1.

Ports:
- `ram_clk`, in, 1: single clock. All logic runs on its rising edge.
- `ram_rst`, in, 1: reset. Synchronous, active-high.
- `ram_addr`, in, `ADDR_MSB`+1: word address.
- `ram_cen`, in, 1: chip enable, active low.
- `ram_wen`, in, `NB`: per-byte write enable, active low. All ones means a read.
- `ram_din`, in, `DATA_WIDTH`: write data.
- `ram_dout`, out, `DATA_WIDTH`: registered read data.
- `init_req`, in, 1: single-cycle pulse that re-runs the clear sequence.
- `init_busy`, out, 1: high while the clear sequence runs.
- `oor_err`, out, 1: one-cycle pulse when an enabled access falls outside `MEM_SIZE`.
- `parity_err`, out, 1: parity mismatch flag, aligned with `ram_dout`.

## Operation
- `DEPTH` = `MEM_SIZE`/`NB` words. `BDEPTH` = `DEPTH`/`BANKS` words per bank.
- Bank select is `ram_addr[log2(BANKS)-1:0]`. The row is `ram_addr >> log2(BANKS)`. When `BANKS`=1 there are no select bits.
- State machine has two states, `ST_INIT` and `ST_RUN`.
- `ST_INIT`:
  - Row counter `init_cnt` counts 0..`BDEPTH`-1.
  - Each cycle writes zero (with correct parity) to row `init_cnt` in all banks in parallel.
  - After row `BDEPTH`-1 is written, the FSM moves to `ST_RUN`.
  - CPU accesses are ignored: no write, `ram_dout` holds 0, `oor_err` stays 0.
- `ST_RUN`:
  - Access occurs only when `ram_cen`=0.
  - Write: byte lane i is updated if `ram_wen[i]`=0. Other lanes keep their contents.
  - Read: all lanes read; any wen pattern returns the pre-write word of the addressed row (read-before-write).
  - `init_req`=1 causes a transition to `ST_INIT` at the next edge, with `init_cnt` set to 0. An access presented in that same cycle is still serviced.
  - `init_req` is ignored in `ST_INIT`; the sequence does not restart.
- Out of range (`ram_addr` ≥ `DEPTH` while `ram_cen`=0 in `ST_RUN`):
  - The write is dropped.
  - Next cycle: `ram_dout`=0 and `oor_err`=1 for that one cycle.
- When `ram_cen`=1, `ram_dout` holds its last value.

## Timing
- Reset values: FSM=`ST_INIT`, `init_cnt`=0, `init_busy`=1, `ram_dout`=0, `oor_err`=0, `parity_err`=0.
- Memory contents are not reset directly; they are cleared by the init sequence.
- Reset asserted mid-sequence restarts the sequence at row 0.
- The init sequence takes exactly `BDEPTH` cycles after `ram_rst` deasserts.
- `init_busy` falls on the edge that writes the last row. The first accepted CPU access is in the following cycle.
- Read latency is one cycle: address at edge N, data valid after edge N+1.
- The bank-select bits are registered alongside the access so the output mux stays aligned.
- Back-to-back accesses are accepted every cycle. No wait states occur in `ST_RUN`.

## Configuration
- `PMEM_PARITY_EN` defined:
  - Each bank stores one extra even-parity bit per byte, `NB` bits per row.
  - Parity is generated on write and on init.
  - On every serviced read, each lane's parity is checked. `parity_err` is asserted in the same cycle as `ram_dout` if any lane mismatches.
  - `parity_err` is 0 for out-of-range reads and when `ram_cen`=1.
- `PMEM_PARITY_EN` undefined:
  - No parity storage or logic.
  - `parity_err` is tied to 0.

## Structure
- Package `pmem_pkg` holds:
  - the state typedef `pmem_state_t` (`ST_INIT`, `ST_RUN`);
  - function `clog2`;
  - function `parity8` (even parity of a byte).
- Sub-module `pmem_bank` is instantiated `BANKS` times via generate. Each instance is a single `BDEPTH`×(`DATA_WIDTH`+parity) array with byte enables and a registered read port.
- The top level holds the FSM, the init counter, address decode and range check, and the output mux.

## Test plan
Use `MEM_SIZE`=64, `DATA_WIDTH`=16, `BANKS`=2, so `DEPTH`=32 and `BDEPTH`=16.
- Reset, then release → `init_busy`=1 for 16 cycles, then 0. Reading every address 0..31 returns 0x0000.
- Write 0xA5C3 to address 5 with `ram_wen`=2'b00, then write 0x11xx with `ram_wen`=2'b01 → read of address 5 returns 0x11C3 one cycle after the address is presented.
- Write 0x1234 to address 2 and 0x5678 to address 3, then read 2, 3, 2 back-to-back → `ram_dout` shows 0x1234, 0x5678, 0x1234 on consecutive cycles.
- Write to address 40 → `oor_err` pulses for one cycle, `ram_dout`=0, and no row changes (full readback is unchanged).
- Pulse `init_req` after writes; pulse it again at cycle 5 of the sequence; assert `ram_rst` at cycle 8 of a later sequence → the busy window is 16 cycles (the second pulse is ignored), the reset restarts it at 16, and all reads then return 0.
- With `PMEM_PARITY_EN`: write 0x00FF to address 7, flip bit 0 of that row in the bank array hierarchically, read address 7 → `parity_err`=1 with `ram_dout`=0x00FE. An unmodified read gives `parity_err`=0.
